// File: rtl/reg_bank_3s.sv
// reg_bank_3s: DEPTH x WIDTH register bank with a 3-state read bus.
//
// Each rising clk edge performs exactly one operation. In priority order:
//   synchronous clear (clr_n low)
//   shift-in at entry 0 (shift_n low)
//   indexed write (wr_n low)
//   hold
// The read port is combinational from the registered state. q is driven
// only while all three oe_n bits are low.
//
// Ports:
//   clk     - clock; all state changes on its rising edge, except reset
//   rst     - asynchronous active-high reset
//   d       - write / shift-in data
//   wr_n    - write enable, active-low
//   wsel    - write entry index
//   shift_n - shift enable, active-low
//   clr_n   - synchronous clear, active-low
//   rsel    - read entry index
//   oe_n    - output enables, active-low; the bus is driven only when all are low
//   q       - 3-state read bus
//   q_en    - high exactly when q is driven
//   vld     - per-entry written-since-clear flags
//   full    - all vld bits set
module reg_bank_3s #(
   parameter int unsigned       WIDTH       = 8,
   parameter int unsigned       DEPTH       = 4,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
   localparam int unsigned      AW          = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             wr_n,
   input  logic [AW-1:0]    wsel,
   input  logic             shift_n,
   input  logic             clr_n,
   input  logic [AW-1:0]    rsel,
   input  logic [2:0]       oe_n,
   output logic [WIDTH-1:0] q,
   output logic             q_en,
   output logic [DEPTH-1:0] vld,
   output logic             full
);

   logic [WIDTH-1:0] ent_q [DEPTH];
   logic [WIDTH-1:0] ent_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;

   // Controls are tested with if (!x). An X or Z on a control input
   // therefore falls through to the lower-priority branch and is never
   // treated as asserted.
   always_comb begin
      ent_d = ent_q;
      vld_d = vld_q;
      if (!clr_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = RESET_VALUE;
         end
         vld_d = '0;
      end else if (!shift_n) begin
         // Entry DEPTH-1 and its flag fall off the end with no indication.
         for (int unsigned i = 1; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i-1];
         end
         ent_d[0] = d;
         vld_d    = {vld_q[DEPTH-2:0], 1'b1};
      end else if (!wr_n) begin
         ent_d[wsel] = d;
         vld_d[wsel] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_q[i] <= RESET_VALUE;
         end
         vld_q <= '0;
      end else begin
         ent_q <= ent_d;
         vld_q <= vld_d;
      end
   end

   // The read path is independent of rst. The bus may therefore drive
   // RESET_VALUE while reset is held.
   assign q_en = ~oe_n[0] & ~oe_n[1] & ~oe_n[2];
   assign q    = q_en ? ent_q[rsel] : 'z;
   assign vld  = vld_q;
   assign full = &vld_q;

endmodule

// File: tb/tb_reg_bank_3s.sv
module tb_reg_bank_3s;

   logic clk = 1'b0;
   logic rst;

   // Bank A: WIDTH=8, DEPTH=4, RESET_VALUE=0
   logic [7:0] a_d;
   logic       a_wr_n, a_shift_n, a_clr_n;
   logic [1:0] a_wsel, a_rsel;
   logic [2:0] a_oe_n;
   logic [7:0] a_q;
   logic       a_q_en;
   logic [3:0] a_vld;
   logic       a_full;

   // Bank B: WIDTH=8, DEPTH=8, RESET_VALUE=0x3C
   logic [7:0] b_d;
   logic       b_wr_n, b_shift_n, b_clr_n;
   logic [2:0] b_wsel, b_rsel;
   logic [2:0] b_oe_n;
   logic [7:0] b_q;
   logic       b_q_en;
   logic [7:0] b_vld;
   logic       b_full;

   reg_bank_3s #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) u_a (
      .clk(clk), .rst(rst), .d(a_d), .wr_n(a_wr_n), .wsel(a_wsel),
      .shift_n(a_shift_n), .clr_n(a_clr_n), .rsel(a_rsel), .oe_n(a_oe_n),
      .q(a_q), .q_en(a_q_en), .vld(a_vld), .full(a_full)
   );

   reg_bank_3s #(.WIDTH(8), .DEPTH(8), .RESET_VALUE(8'h3C)) u_b (
      .clk(clk), .rst(rst), .d(b_d), .wr_n(b_wr_n), .wsel(b_wsel),
      .shift_n(b_shift_n), .clr_n(b_clr_n), .rsel(b_rsel), .oe_n(b_oe_n),
      .q(b_q), .q_en(b_q_en), .vld(b_vld), .full(b_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       clr_n;
      logic       shift_n;
      logic       wr_n;
      logic [1:0] wsel;
      logic [7:0] d;
      logic [1:0] rsel;
      logic [2:0] oe_n;
      logic [7:0] eq;
      logic       eqen;
      logic [3:0] evld;
      logic       efull;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;

   vec_t tbl [12];
   sb_t  sbq [$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(logic c, logic s, logic w, logic [1:0] ws, logic [7:0] dd,
                               logic [1:0] rs, logic [2:0] oe, logic [7:0] eq,
                               logic eqen, logic [3:0] ev, logic ef);
      vec_t v;
      v.clr_n = c; v.shift_n = s; v.wr_n = w; v.wsel = ws; v.d = dd;
      v.rsel = rs; v.oe_n = oe; v.eq = eq; v.eqen = eqen; v.evld = ev; v.efull = ef;
      return v;
   endfunction

   task automatic expect_val(string name, logic [31:0] e);
      sb_t r;
      r.name = name;
      r.exp  = e;
      sbq.push_back(r);
   endtask

   task automatic check_val(logic [31:0] act);
      sb_t r;
      n_vec++;
      if (sbq.size() == 0) begin
         n_err++;
         $display("FAIL scoreboard_empty: got %h with nothing expected", act);
      end else begin
         r = sbq.pop_front();
         if (act !== r.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", r.name, act, r.exp);
         end
      end
   endtask

   task automatic a_idle();
      a_clr_n = 1'b1; a_shift_n = 1'b1; a_wr_n = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // table: inputs for one edge, expected outputs after it
      tbl[0]  = mk(1, 1, 0, 2'd2, 8'hA5, 2'd2, 3'b000, 8'hA5, 1, 4'b0100, 0);
      tbl[1]  = mk(1, 1, 1, 2'd0, 8'h00, 2'd2, 3'b010, 8'h00, 0, 4'b0100, 0);
      tbl[2]  = mk(1, 1, 1, 2'd0, 8'h00, 2'd2, 3'b000, 8'hA5, 1, 4'b0100, 0);
      tbl[3]  = mk(1, 0, 1, 2'd0, 8'h11, 2'd0, 3'b000, 8'h11, 1, 4'b1001, 0);
      tbl[4]  = mk(1, 0, 1, 2'd0, 8'h22, 2'd1, 3'b000, 8'h11, 1, 4'b0011, 0);
      tbl[5]  = mk(1, 0, 1, 2'd0, 8'h33, 2'd2, 3'b000, 8'h11, 1, 4'b0111, 0);
      tbl[6]  = mk(1, 0, 1, 2'd0, 8'h44, 2'd3, 3'b000, 8'h11, 1, 4'b1111, 1);
      tbl[7]  = mk(1, 0, 1, 2'd0, 8'h55, 2'd3, 3'b000, 8'h22, 1, 4'b1111, 1);
      tbl[8]  = mk(0, 0, 0, 2'd1, 8'h77, 2'd1, 3'b000, 8'h00, 1, 4'b0000, 0);
      tbl[9]  = mk(1, 1, 0, 2'd1, 8'h77, 2'd1, 3'b000, 8'h77, 1, 4'b0010, 0);
      tbl[10] = mk(1, 0, 0, 2'd3, 8'h99, 2'd0, 3'b000, 8'h99, 1, 4'b0101, 0);
      tbl[11] = mk(1, 1, 1, 2'd0, 8'h00, 2'd2, 3'b100, 8'h00, 0, 4'b0101, 0);

      rst = 1'b1;
      a_idle(); a_d = '0; a_wsel = '0; a_rsel = '0; a_oe_n = 3'b000;
      b_clr_n = 1'b1; b_shift_n = 1'b1; b_wr_n = 1'b1;
      b_d = '0; b_wsel = '0; b_rsel = '0; b_oe_n = 3'b000;

      // Reset state, read while rst is still high
      #2;
      expect_val("rst_q", 8'h00);    check_val(a_q);
      expect_val("rst_qen", 1'b1);   check_val(a_q_en);
      expect_val("rst_vld", 4'h0);   check_val(a_vld);
      expect_val("rst_full", 1'b0);  check_val(a_full);
      expect_val("rst_b_q", 8'h3C);  check_val(b_q);
      repeat (2) tick();
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         a_clr_n = tbl[i].clr_n; a_shift_n = tbl[i].shift_n; a_wr_n = tbl[i].wr_n;
         a_wsel = tbl[i].wsel; a_d = tbl[i].d; a_rsel = tbl[i].rsel; a_oe_n = tbl[i].oe_n;
         if (i == 0) begin
            // No write-through: the old value is visible until the edge.
            #1;
            expect_val("pre_edge_q", 8'h00);
            check_val(a_q);
         end
         if (tbl[i].eqen) expect_val($sformatf("v%0d_q", i), tbl[i].eq);
         expect_val($sformatf("v%0d_qen", i), tbl[i].eqen);
         expect_val($sformatf("v%0d_vld", i), tbl[i].evld);
         expect_val($sformatf("v%0d_full", i), tbl[i].efull);
         tick();
         if (tbl[i].eqen) check_val(a_q);
         check_val(a_q_en);
         check_val(a_vld);
         check_val(a_full);
         if (i == 1) begin
            // Re-enable the bus without a clock edge.
            a_oe_n = 3'b000;
            #1;
            expect_val("oe_reen_q", 8'hA5);  check_val(a_q);
            expect_val("oe_reen_qen", 1'b1); check_val(a_q_en);
         end
         if (i == 7) begin
            a_idle();
            for (int r = 0; r < 4; r++) begin
               expect_val($sformatf("shift5_e%0d", r), 8'h55 - 8'(r) * 8'h11);
               a_rsel = 2'(r);
               #1;
               check_val(a_q);
            end
         end
      end

      // Fill the bank, then reset asynchronously between edges.
      a_idle(); a_oe_n = 3'b000; a_rsel = 2'd0;
      for (int k = 0; k < 4; k++) begin
         a_shift_n = 1'b0; a_d = 8'hF0 + 8'(k);
         tick();
      end
      a_idle();
      expect_val("prefill_full", 1'b1); check_val(a_full);
      #2 rst = 1'b1;
      #1;
      expect_val("async_vld", 4'h0);  check_val(a_vld);
      expect_val("async_full", 1'b0); check_val(a_full);
      expect_val("async_q", 8'h00);   check_val(a_q);
      a_wr_n = 1'b0; a_wsel = 2'd0; a_d = 8'hFF;
      repeat (2) tick();
      expect_val("rst_hold_vld", 4'h0); check_val(a_vld);
      expect_val("rst_hold_q", 8'h00);  check_val(a_q);
      rst = 1'b0;
      tick();
      expect_val("post_rst_q", 8'hFF);    check_val(a_q);
      expect_val("post_rst_vld", 4'h1);   check_val(a_vld);
      a_idle();

      // Bank B: non-zero RESET_VALUE, DEPTH=8
      for (int r = 0; r < 8; r++) begin
         expect_val($sformatf("b_rst_e%0d", r), 8'h3C);
         b_rsel = 3'(r);
         #1;
         check_val(b_q);
      end
      b_wr_n = 1'b0; b_wsel = 3'd7; b_d = 8'hE7; b_rsel = 3'd7;
      tick();
      b_wr_n = 1'b1;
      expect_val("b_wr7_q", 8'hE7);    check_val(b_q);
      expect_val("b_wr7_vld", 8'h80);  check_val(b_vld);
      b_shift_n = 1'b0; b_d = 8'h01;
      tick();
      b_shift_n = 1'b1;
      expect_val("b_sh_e7", 8'h3C);    check_val(b_q);
      expect_val("b_sh_vld", 8'h01);   check_val(b_vld);
      b_rsel = 3'd0;
      #1;
      expect_val("b_sh_e0", 8'h01);    check_val(b_q);
      b_clr_n = 1'b0;
      tick();
      b_clr_n = 1'b1;
      expect_val("b_clr_e0", 8'h3C);   check_val(b_q);
      expect_val("b_clr_vld", 8'h00);  check_val(b_vld);

      if (sbq.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
